// File: rtl/rca_config_unit.sv
// rca_config_unit: queued configuration front-end for a set of RCAs.
// Instructions are range-checked at accept, held in a small FIFO and applied
// to the configuration registers once their target RCA (or all RCAs for the
// shared grid/IO muxes) is idle. Illegal instructions are dropped with cfg_err.
module rca_config_unit #(
  parameter int NUM_RCAS        = 4,
  parameter int NUM_READ_PORTS  = 5,
  parameter int NUM_WRITE_PORTS = 5,
  parameter int NUM_GRID_MUXES  = 30,
  parameter int GRID_SEL_W      = 3,
  parameter int NUM_IO_UNITS    = 6,
  parameter int IO_SEL_W        = 4,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       cfg_valid,
  output logic                                       cfg_ready,
  input  logic [2:0]                                 cfg_funct3,
  input  logic [6:0]                                 cfg_funct7,
  input  logic [31:0]                                cfg_rs1,
  input  logic [31:0]                                cfg_rs2,
  input  logic [NUM_RCAS-1:0]                        rca_busy,
  output logic [NUM_RCAS-1:0]                        cfg_pending,
  output logic                                       cfg_err,
  output logic [NUM_RCAS*NUM_READ_PORTS*5-1:0]       read_addr,
  output logic [NUM_RCAS*NUM_WRITE_PORTS*5-1:0]      wr_addr_fb,
  output logic [NUM_RCAS*NUM_WRITE_PORTS*5-1:0]      wr_addr_nfb,
  output logic [NUM_RCAS*NUM_WRITE_PORTS*$clog2(NUM_IO_UNITS+1)-1:0] res_sel_fb,
  output logic [NUM_RCAS*NUM_WRITE_PORTS*$clog2(NUM_IO_UNITS+1)-1:0] res_sel_nfb,
  output logic [NUM_GRID_MUXES*GRID_SEL_W-1:0]       grid_sel,
  output logic [NUM_IO_UNITS*IO_SEL_W-1:0]           io_sel,
  output logic [NUM_RCAS*NUM_READ_PORTS-1:0]         io_use
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int RS_W  = $clog2(NUM_IO_UNITS + 1);

  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [RS_W-1:0]  RES_UNUSED = RS_W'(NUM_IO_UNITS);
  localparam logic [31:0]      N_RCAS_U   = 32'(NUM_RCAS);
  localparam logic [31:0]      N_RP_U     = 32'(NUM_READ_PORTS);
  localparam logic [31:0]      N_WP_U     = 32'(NUM_WRITE_PORTS);
  localparam logic [31:0]      N_GRID_U   = 32'(NUM_GRID_MUXES);
  localparam logic [31:0]      N_IO_U     = 32'(NUM_IO_UNITS);

  // Queue storage and control
  logic [2:0]          q_f3_q  [QUEUE_DEPTH];
  logic [2:0]          q_f3_d  [QUEUE_DEPTH];
  logic [6:0]          q_f7_q  [QUEUE_DEPTH];
  logic [6:0]          q_f7_d  [QUEUE_DEPTH];
  logic [31:0]         q_rs1_q [QUEUE_DEPTH];
  logic [31:0]         q_rs1_d [QUEUE_DEPTH];
  logic [31:0]         q_rs2_q [QUEUE_DEPTH];
  logic [31:0]         q_rs2_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [NUM_RCAS-1:0] pending_q, pending_d;

  // Configuration registers
  logic [4:0]                rd_addr_q [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0]                rd_addr_d [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0]                wa_fb_q   [NUM_RCAS][NUM_WRITE_PORTS];
  logic [4:0]                wa_fb_d   [NUM_RCAS][NUM_WRITE_PORTS];
  logic [4:0]                wa_nfb_q  [NUM_RCAS][NUM_WRITE_PORTS];
  logic [4:0]                wa_nfb_d  [NUM_RCAS][NUM_WRITE_PORTS];
  logic [RS_W-1:0]           rs_fb_q   [NUM_RCAS][NUM_WRITE_PORTS];
  logic [RS_W-1:0]           rs_fb_d   [NUM_RCAS][NUM_WRITE_PORTS];
  logic [RS_W-1:0]           rs_nfb_q  [NUM_RCAS][NUM_WRITE_PORTS];
  logic [RS_W-1:0]           rs_nfb_d  [NUM_RCAS][NUM_WRITE_PORTS];
  logic [GRID_SEL_W-1:0]     grid_q    [NUM_GRID_MUXES];
  logic [GRID_SEL_W-1:0]     grid_d    [NUM_GRID_MUXES];
  logic [IO_SEL_W-1:0]       io_sel_q  [NUM_IO_UNITS];
  logic [IO_SEL_W-1:0]       io_sel_d  [NUM_IO_UNITS];
  logic [NUM_READ_PORTS-1:0] io_use_q  [NUM_RCAS];
  logic [NUM_READ_PORTS-1:0] io_use_d  [NUM_RCAS];

  // Combinational helpers
  logic [31:0] in_f7_s, in_port_s;
  logic        in_rca_ok_s, legal_s, fire_s, enq_s;
  logic [2:0]  head_f3_s;
  logic [31:0] head_f7_s, head_rs1_s, head_rs2_s, head_port_s;
  logic        head_busy_s, head_ok_s, apply_s;
  logic        wr_rd_s, wr_wfb_s, wr_wnfb_s, wr_rsfb_s, wr_rsnfb_s;
  logic        wr_grid_s, wr_iosel_s, wr_iouse_s;
  logic        unused_s;

  // Upper operand bits beyond the widest field are carried but never consumed.
  assign unused_s = ^{head_rs1_s, head_rs2_s};

  // Classify the incoming instruction and range-check its target indices.
  always_comb begin
    in_f7_s     = {25'd0, cfg_funct7};
    in_port_s   = {29'd0, cfg_rs1[2:0]};
    in_rca_ok_s = (in_f7_s < N_RCAS_U);
    legal_s     = 1'b0;
    case (cfg_funct3)
      3'b001:  legal_s = in_rca_ok_s &&
                         (cfg_rs1[3] ? (in_port_s < N_WP_U) : (in_port_s < N_RP_U));
      3'b010:  legal_s = (cfg_rs1 < N_GRID_U);
      3'b011:  legal_s = (cfg_rs1 < N_IO_U);
      3'b100:  legal_s = in_rca_ok_s && (in_port_s < N_WP_U);
      3'b101:  legal_s = in_rca_ok_s;
      default: legal_s = 1'b0;
    endcase
  end

  // Decide whether the head entry may apply this edge (busy gating, no reordering).
  always_comb begin
    head_f3_s   = q_f3_q[rd_ptr_q];
    head_f7_s   = {25'd0, q_f7_q[rd_ptr_q]};
    head_rs1_s  = q_rs1_q[rd_ptr_q];
    head_rs2_s  = q_rs2_q[rd_ptr_q];
    head_port_s = {29'd0, head_rs1_s[2:0]};
    head_busy_s = 1'b0;
    for (int r = 0; r < NUM_RCAS; r++) begin
      head_busy_s = head_busy_s | ((head_f7_s == 32'(r)) & rca_busy[r]);
    end
    case (head_f3_s)
      3'b001, 3'b100, 3'b101: head_ok_s = ~head_busy_s;
      3'b010, 3'b011:         head_ok_s = ~|rca_busy;
      default:                head_ok_s = 1'b1;
    endcase
    apply_s = (count_q != CNT_ZERO) && head_ok_s;
  end

  // Next queue state: enqueue, dequeue, occupancy, handshake and pending map.
  always_comb begin
    fire_s   = cfg_valid & ready_q;
    enq_s    = fire_s & legal_s;
    err_d    = fire_s & ~legal_s;
    count_d  = count_q + {{(CNT_W-1){1'b0}}, enq_s} - {{(CNT_W-1){1'b0}}, apply_s};
    wr_ptr_d = enq_s   ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = apply_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    ready_d  = (count_d != CNT_FULL);
    for (int k = 0; k < QUEUE_DEPTH; k++) begin
      q_f3_d[k]  = (enq_s && (wr_ptr_q == PTR_W'(k))) ? cfg_funct3 : q_f3_q[k];
      q_f7_d[k]  = (enq_s && (wr_ptr_q == PTR_W'(k))) ? cfg_funct7 : q_f7_q[k];
      q_rs1_d[k] = (enq_s && (wr_ptr_q == PTR_W'(k))) ? cfg_rs1    : q_rs1_q[k];
      q_rs2_d[k] = (enq_s && (wr_ptr_q == PTR_W'(k))) ? cfg_rs2    : q_rs2_q[k];
    end
    pending_d = {NUM_RCAS{1'b0}};
    for (int k = 0; k < QUEUE_DEPTH; k++) begin
      logic [PTR_W-1:0] slot;
      logic             live, all_rcas, one_rca;
      slot     = rd_ptr_d + PTR_W'(k);
      live     = (CNT_W'(k) < count_d);
      all_rcas = live && ((q_f3_d[slot] == 3'b010) || (q_f3_d[slot] == 3'b011));
      one_rca  = live && ((q_f3_d[slot] == 3'b001) || (q_f3_d[slot] == 3'b100) ||
                          (q_f3_d[slot] == 3'b101));
      for (int r = 0; r < NUM_RCAS; r++) begin
        pending_d[r] = pending_d[r] | all_rcas | (one_rca & (q_f7_d[slot] == 7'(r)));
      end
    end
  end

  // Apply the head entry to the addressed configuration field.
  always_comb begin
    wr_rd_s    = apply_s && (head_f3_s == 3'b001) && !head_rs1_s[3];
    wr_wfb_s   = apply_s && (head_f3_s == 3'b001) &&  head_rs1_s[3] &&  head_rs1_s[4];
    wr_wnfb_s  = apply_s && (head_f3_s == 3'b001) &&  head_rs1_s[3] && !head_rs1_s[4];
    wr_rsfb_s  = apply_s && (head_f3_s == 3'b100) &&  head_rs1_s[3];
    wr_rsnfb_s = apply_s && (head_f3_s == 3'b100) && !head_rs1_s[3];
    wr_grid_s  = apply_s && (head_f3_s == 3'b010);
    wr_iosel_s = apply_s && (head_f3_s == 3'b011);
    wr_iouse_s = apply_s && (head_f3_s == 3'b101);
    for (int r = 0; r < NUM_RCAS; r++) begin
      logic hit;
      hit = (head_f7_s == 32'(r));
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        rd_addr_d[r][p] = (wr_rd_s && hit && (head_port_s == 32'(p))) ?
                          head_rs2_s[4:0] : rd_addr_q[r][p];
      end
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        wa_fb_d[r][p]  = (wr_wfb_s && hit && (head_port_s == 32'(p))) ?
                         head_rs2_s[4:0] : wa_fb_q[r][p];
        wa_nfb_d[r][p] = (wr_wnfb_s && hit && (head_port_s == 32'(p))) ?
                         head_rs2_s[4:0] : wa_nfb_q[r][p];
        rs_fb_d[r][p]  = (wr_rsfb_s && hit && (head_port_s == 32'(p))) ?
                         head_rs2_s[RS_W-1:0] : rs_fb_q[r][p];
        rs_nfb_d[r][p] = (wr_rsnfb_s && hit && (head_port_s == 32'(p))) ?
                         head_rs2_s[RS_W-1:0] : rs_nfb_q[r][p];
      end
      io_use_d[r] = (wr_iouse_s && hit) ? head_rs1_s[NUM_READ_PORTS-1:0] : io_use_q[r];
    end
    for (int g = 0; g < NUM_GRID_MUXES; g++) begin
      grid_d[g] = (wr_grid_s && (head_rs1_s == 32'(g))) ?
                  head_rs2_s[GRID_SEL_W-1:0] : grid_q[g];
    end
    for (int i = 0; i < NUM_IO_UNITS; i++) begin
      io_sel_d[i] = (wr_iosel_s && (head_rs1_s == 32'(i))) ?
                    head_rs2_s[IO_SEL_W-1:0] : io_sel_q[i];
    end
  end

  // Queue registers; reset discards every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= CNT_ZERO;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
      pending_q <= {NUM_RCAS{1'b0}};
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
        q_f3_q[k]  <= 3'd0;
        q_f7_q[k]  <= 7'd0;
        q_rs1_q[k] <= 32'd0;
        q_rs2_q[k] <= 32'd0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      pending_q <= pending_d;
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
        q_f3_q[k]  <= q_f3_d[k];
        q_f7_q[k]  <= q_f7_d[k];
        q_rs1_q[k] <= q_rs1_d[k];
        q_rs2_q[k] <= q_rs2_d[k];
      end
    end
  end

  // Configuration registers; reset returns every field to its unused value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        for (int p = 0; p < NUM_READ_PORTS; p++) rd_addr_q[r][p] <= 5'd0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
          wa_fb_q[r][p]  <= 5'd0;
          wa_nfb_q[r][p] <= 5'd0;
          rs_fb_q[r][p]  <= RES_UNUSED;
          rs_nfb_q[r][p] <= RES_UNUSED;
        end
        io_use_q[r] <= {NUM_READ_PORTS{1'b0}};
      end
      for (int g = 0; g < NUM_GRID_MUXES; g++) grid_q[g] <= {GRID_SEL_W{1'b0}};
      for (int i = 0; i < NUM_IO_UNITS; i++) io_sel_q[i] <= {IO_SEL_W{1'b0}};
    end else begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        for (int p = 0; p < NUM_READ_PORTS; p++) rd_addr_q[r][p] <= rd_addr_d[r][p];
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
          wa_fb_q[r][p]  <= wa_fb_d[r][p];
          wa_nfb_q[r][p] <= wa_nfb_d[r][p];
          rs_fb_q[r][p]  <= rs_fb_d[r][p];
          rs_nfb_q[r][p] <= rs_nfb_d[r][p];
        end
        io_use_q[r] <= io_use_d[r];
      end
      for (int g = 0; g < NUM_GRID_MUXES; g++) grid_q[g] <= grid_d[g];
      for (int i = 0; i < NUM_IO_UNITS; i++) io_sel_q[i] <= io_sel_d[i];
    end
  end

  assign cfg_ready   = ready_q;
  assign cfg_err     = err_q;
  assign cfg_pending = pending_q;

  for (genvar r = 0; r < NUM_RCAS; r++) begin : g_rca
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rp
      assign read_addr[(r*NUM_READ_PORTS+p)*5 +: 5] = rd_addr_q[r][p];
    end
    for (genvar p = 0; p < NUM_WRITE_PORTS; p++) begin : g_wp
      assign wr_addr_fb [(r*NUM_WRITE_PORTS+p)*5 +: 5]       = wa_fb_q[r][p];
      assign wr_addr_nfb[(r*NUM_WRITE_PORTS+p)*5 +: 5]       = wa_nfb_q[r][p];
      assign res_sel_fb [(r*NUM_WRITE_PORTS+p)*RS_W +: RS_W] = rs_fb_q[r][p];
      assign res_sel_nfb[(r*NUM_WRITE_PORTS+p)*RS_W +: RS_W] = rs_nfb_q[r][p];
    end
    assign io_use[r*NUM_READ_PORTS +: NUM_READ_PORTS] = io_use_q[r];
  end

  for (genvar g = 0; g < NUM_GRID_MUXES; g++) begin : g_grid
    assign grid_sel[g*GRID_SEL_W +: GRID_SEL_W] = grid_q[g];
  end

  for (genvar i = 0; i < NUM_IO_UNITS; i++) begin : g_io
    assign io_sel[i*IO_SEL_W +: IO_SEL_W] = io_sel_q[i];
  end

endmodule

// File: tb/tb_rca_config_unit.sv
// tb_rca_config_unit: directed scenarios plus randomized traffic, checked
// against a queue-based behavioural model of the configuration unit.
module tb_rca_config_unit;

  localparam int NR  = 4;
  localparam int NRP = 5;
  localparam int NWP = 5;
  localparam int NG  = 30;
  localparam int GW  = 3;
  localparam int NIO = 6;
  localparam int IOW = 4;
  localparam int QD  = 4;
  localparam int RSW = $clog2(NIO + 1);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cfg_valid = 1'b0;
  logic                  cfg_ready;
  logic [2:0]            cfg_funct3 = 3'd0;
  logic [6:0]            cfg_funct7 = 7'd0;
  logic [31:0]           cfg_rs1 = 32'd0;
  logic [31:0]           cfg_rs2 = 32'd0;
  logic [NR-1:0]         rca_busy = '0;
  logic [NR-1:0]         cfg_pending;
  logic                  cfg_err;
  logic [NR*NRP*5-1:0]   read_addr;
  logic [NR*NWP*5-1:0]   wr_addr_fb, wr_addr_nfb;
  logic [NR*NWP*RSW-1:0] res_sel_fb, res_sel_nfb;
  logic [NG*GW-1:0]      grid_sel;
  logic [NIO*IOW-1:0]    io_sel;
  logic [NR*NRP-1:0]     io_use;

  rca_config_unit #(
    .NUM_RCAS(NR), .NUM_READ_PORTS(NRP), .NUM_WRITE_PORTS(NWP),
    .NUM_GRID_MUXES(NG), .GRID_SEL_W(GW), .NUM_IO_UNITS(NIO),
    .IO_SEL_W(IOW), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_funct3(cfg_funct3), .cfg_funct7(cfg_funct7), .cfg_rs1(cfg_rs1),
    .cfg_rs2(cfg_rs2), .rca_busy(rca_busy), .cfg_pending(cfg_pending),
    .cfg_err(cfg_err), .read_addr(read_addr), .wr_addr_fb(wr_addr_fb),
    .wr_addr_nfb(wr_addr_nfb), .res_sel_fb(res_sel_fb), .res_sel_nfb(res_sel_nfb),
    .grid_sel(grid_sel), .io_sel(io_sel), .io_use(io_use)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } ent_t;

  // Reference model state
  ent_t mq[$];
  bit   m_ready;
  bit   m_err;
  int   m_ra[NR][NRP];
  int   m_wfb[NR][NWP];
  int   m_wnfb[NR][NWP];
  int   m_rsfb[NR][NWP];
  int   m_rsnfb[NR][NWP];
  int   m_grid[NG];
  int   m_iosel[NIO];
  int   m_iouse[NR];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_ready = 1'b1;
    m_err   = 1'b0;
    for (int r = 0; r < NR; r++) begin
      for (int p = 0; p < NRP; p++) m_ra[r][p] = 0;
      for (int p = 0; p < NWP; p++) begin
        m_wfb[r][p] = 0; m_wnfb[r][p] = 0;
        m_rsfb[r][p] = NIO; m_rsnfb[r][p] = NIO;
      end
      m_iouse[r] = 0;
    end
    for (int g = 0; g < NG; g++) m_grid[g] = 0;
    for (int i = 0; i < NIO; i++) m_iosel[i] = 0;
  endfunction

  function automatic bit m_legal(ent_t e);
    int  port = int'(e.rs1[2:0]);
    bit  rca_ok = (int'(e.f7) < NR);
    case (e.f3)
      3'd1:    return rca_ok && (port < (e.rs1[3] ? NWP : NRP));
      3'd2:    return e.rs1 < 32'(NG);
      3'd3:    return e.rs1 < 32'(NIO);
      3'd4:    return rca_ok && (port < NWP);
      3'd5:    return rca_ok;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_blocked(ent_t e, logic [NR-1:0] b);
    if (e.f3 == 3'd2 || e.f3 == 3'd3) return (b != '0);
    return b[int'(e.f7)];
  endfunction

  function automatic void m_apply(ent_t e);
    int f = int'(e.f7);
    int p = int'(e.rs1[2:0]);
    case (e.f3)
      3'd1: begin
        if (!e.rs1[3])     m_ra[f][p]   = int'(e.rs2 % 32);
        else if (e.rs1[4]) m_wfb[f][p]  = int'(e.rs2 % 32);
        else               m_wnfb[f][p] = int'(e.rs2 % 32);
      end
      3'd2: m_grid[int'(e.rs1)]  = int'(e.rs2 % (1 << GW));
      3'd3: m_iosel[int'(e.rs1)] = int'(e.rs2 % (1 << IOW));
      3'd4: begin
        if (e.rs1[3]) m_rsfb[f][p]  = int'(e.rs2 % (1 << RSW));
        else          m_rsnfb[f][p] = int'(e.rs2 % (1 << RSW));
      end
      3'd5: m_iouse[f] = int'(e.rs1 % (1 << NRP));
      default: ;
    endcase
  endfunction

  function automatic logic [NR-1:0] m_pending();
    logic [NR-1:0] v = '0;
    foreach (mq[k]) begin
      for (int r = 0; r < NR; r++) begin
        if (mq[k].f3 == 3'd2 || mq[k].f3 == 3'd3) v[r] = 1'b1;
        else if (int'(mq[k].f7) == r) v[r] = 1'b1;
      end
    end
    return v;
  endfunction

  // One rising edge of the model: head applies first, then a new accept lands behind it.
  function automatic void model_edge();
    ent_t e;
    bit   acc = cfg_valid && m_ready;
    e.f3 = cfg_funct3; e.f7 = cfg_funct7; e.rs1 = cfg_rs1; e.rs2 = cfg_rs2;
    if (mq.size() > 0 && !m_blocked(mq[0], rca_busy)) begin
      m_apply(mq[0]);
      void'(mq.pop_front());
    end
    m_err = 1'b0;
    if (acc) begin
      if (m_legal(e)) mq.push_back(e);
      else m_err = 1'b1;
    end
    m_ready = (mq.size() < QD);
  endfunction

  task automatic compare_all();
    logic [NR*NRP*5-1:0]   e_ra;
    logic [NR*NWP*5-1:0]   e_wfb, e_wnfb;
    logic [NR*NWP*RSW-1:0] e_rsfb, e_rsnfb;
    logic [NG*GW-1:0]      e_grid;
    logic [NIO*IOW-1:0]    e_iosel;
    logic [NR*NRP-1:0]     e_iouse;
    for (int r = 0; r < NR; r++) begin
      for (int p = 0; p < NRP; p++) e_ra[(r*NRP+p)*5 +: 5] = 5'(m_ra[r][p]);
      for (int p = 0; p < NWP; p++) begin
        e_wfb[(r*NWP+p)*5 +: 5]       = 5'(m_wfb[r][p]);
        e_wnfb[(r*NWP+p)*5 +: 5]      = 5'(m_wnfb[r][p]);
        e_rsfb[(r*NWP+p)*RSW +: RSW]  = RSW'(m_rsfb[r][p]);
        e_rsnfb[(r*NWP+p)*RSW +: RSW] = RSW'(m_rsnfb[r][p]);
      end
      e_iouse[r*NRP +: NRP] = NRP'(m_iouse[r]);
    end
    for (int g = 0; g < NG; g++) e_grid[g*GW +: GW] = GW'(m_grid[g]);
    for (int i = 0; i < NIO; i++) e_iosel[i*IOW +: IOW] = IOW'(m_iosel[i]);
    check_eq("ready",       128'(cfg_ready),   128'(m_ready));
    check_eq("err",         128'(cfg_err),     128'(m_err));
    check_eq("pending",     128'(cfg_pending), 128'(m_pending()));
    check_eq("read_addr",   128'(read_addr),   128'(e_ra));
    check_eq("wr_addr_fb",  128'(wr_addr_fb),  128'(e_wfb));
    check_eq("wr_addr_nfb", 128'(wr_addr_nfb), 128'(e_wnfb));
    check_eq("res_sel_fb",  128'(res_sel_fb),  128'(e_rsfb));
    check_eq("res_sel_nfb", 128'(res_sel_nfb), 128'(e_rsnfb));
    check_eq("grid_sel",    128'(grid_sel),    128'(e_grid));
    check_eq("io_sel",      128'(io_sel),      128'(e_iosel));
    check_eq("io_use",      128'(io_use),      128'(e_iouse));
  endtask

  task automatic step_cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] rs1, input logic [31:0] rs2);
    cfg_valid = 1'b1; cfg_funct3 = f3; cfg_funct7 = f7; cfg_rs1 = rs1; cfg_rs2 = rs2;
    step_cycle();
    cfg_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    step_cycle();
    step_cycle();
    check_eq("rst_ready", 128'(cfg_ready), 128'd1);
    check_eq("rst_res_sel_fb0", 128'(res_sel_fb[RSW-1:0]), 128'd6);
    rst_n = 1'b1;
    step_cycle();

    // Single read-address write to an idle RCA.
    send(3'd1, 7'd2, 32'h3, 32'd7);
    check_eq("r031_pend", 128'(cfg_pending[2]), 128'd1);
    check_eq("r031_pre",  128'(read_addr[(2*NRP+3)*5 +: 5]), 128'd0);
    step_cycle();
    check_eq("r031_addr",     128'(read_addr[(2*NRP+3)*5 +: 5]), 128'd7);
    check_eq("r031_pend_clr", 128'(cfg_pending[2]), 128'd0);

    // Blocked head stalls a later entry for an idle RCA.
    rca_busy = 4'b0010;
    send(3'd4, 7'd1, 32'hA, 32'd4);
    send(3'd5, 7'd0, 32'h15, 32'd0);
    step_cycle();
    check_eq("r032_pend", 128'(cfg_pending[1:0]), 128'd3);
    check_eq("r032_held", 128'(io_use[NRP-1:0]), 128'd0);
    rca_busy = 4'b0000;
    step_cycle();
    check_eq("r032_first",  128'(res_sel_fb[(1*NWP+2)*RSW +: RSW]), 128'd4);
    check_eq("r032_second_wait", 128'(io_use[NRP-1:0]), 128'd0);
    step_cycle();
    check_eq("r032_second", 128'(io_use[NRP-1:0]), 128'h15);

    // Fill the queue behind a busy RCA.
    rca_busy = 4'b0001;
    for (int i = 0; i < QD; i++) send(3'd1, 7'd0, 32'(i), 32'(i + 10));
    check_eq("r033_full", 128'(cfg_ready), 128'd0);
    cfg_valid = 1'b1; cfg_funct3 = 3'd1; cfg_funct7 = 7'd0; cfg_rs1 = 32'd4; cfg_rs2 = 32'd9;
    step_cycle();
    check_eq("r033_still_full", 128'(cfg_ready), 128'd0);
    rca_busy = 4'b0000;
    step_cycle();
    check_eq("r033_ready_back", 128'(cfg_ready), 128'd1);
    step_cycle();
    cfg_valid = 1'b0;
    for (int i = 0; i < 6; i++) step_cycle();
    check_eq("r033_addr0", 128'(read_addr[4:0]), 128'd10);
    check_eq("r033_addr4", 128'(read_addr[24:20]), 128'd9);

    // Rejected instructions.
    send(3'd6, 7'd0, 32'd0, 32'd0);
    check_eq("r034_err_f3", 128'(cfg_err), 128'd1);
    step_cycle();
    check_eq("r034_err_clr", 128'(cfg_err), 128'd0);
    send(3'd1, 7'd5, 32'd0, 32'd1);
    check_eq("r034_err_rca", 128'(cfg_err), 128'd1);
    step_cycle();

    // Grid mux write waits for every RCA to be idle; index 30 is out of range.
    rca_busy = 4'b0100;
    send(3'd2, 7'd0, 32'd29, 32'd5);
    step_cycle();
    check_eq("r035_held", 128'(grid_sel[29*GW +: GW]), 128'd0);
    rca_busy = 4'b0000;
    step_cycle();
    check_eq("r035_grid", 128'(grid_sel[29*GW +: GW]), 128'd5);
    send(3'd2, 7'd0, 32'd30, 32'd1);
    check_eq("r035_err", 128'(cfg_err), 128'd1);
    step_cycle();

    // Reset with entries queued discards them.
    rca_busy = 4'b1111;
    send(3'd1, 7'd3, 32'd1, 32'd9);
    send(3'd2, 7'd0, 32'd0, 32'd3);
    send(3'd5, 7'd1, 32'd7, 32'd0);
    rst_n = 1'b0;
    step_cycle();
    check_eq("r036_ready", 128'(cfg_ready), 128'd1);
    check_eq("r036_pend",  128'(cfg_pending), 128'd0);
    check_eq("r036_grid_rst", 128'(grid_sel[29*GW +: GW]), 128'd0);
    rst_n = 1'b1;
    rca_busy = 4'b0000;
    for (int i = 0; i < 3; i++) step_cycle();
    check_eq("r036_no_stale_ra",   128'(read_addr[(3*NRP+1)*5 +: 5]), 128'd0);
    check_eq("r036_no_stale_grid", 128'(grid_sel[GW-1:0]), 128'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      cfg_valid  = ($urandom_range(0, 2) != 0);
      cfg_funct3 = 3'($urandom_range(0, 7));
      cfg_funct7 = 7'($urandom_range(0, 5));
      cfg_rs1    = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 35));
      cfg_rs2    = 32'($urandom);
      rca_busy   = ($urandom_range(0, 2) == 0) ? NR'($urandom) : '0;
      rst_n      = ($urandom_range(0, 399) != 0);
      step_cycle();
    end
    rst_n = 1'b1;
    cfg_valid = 1'b0;
    rca_busy = '0;
    for (int i = 0; i < 8; i++) step_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rca_config_unit.md
RCA_CONFIG_UNIT -- requirements
Module: rca_config_unit

Interface
REQ-001 SHALL have parameter NUM_RCAS, default 4: number of RCAs configured.
REQ-002 SHALL have parameter NUM_READ_PORTS, default 5: read ports per RCA.
REQ-003 SHALL have parameter NUM_WRITE_PORTS, default 5: write ports per RCA.
REQ-004 SHALL have parameter NUM_GRID_MUXES, default 30, with sel width GRID_SEL_W, default 3.
REQ-005 SHALL have parameter NUM_IO_UNITS, default 6, with IO mux sel width IO_SEL_W, default 4.
REQ-006 SHALL have parameter QUEUE_DEPTH, default 4 (power of two, at least 2): pending config entries.
REQ-007 SHALL have a single clock and an asynchronous, active-low reset: clk input 1; rst_n input 1, asynchronous assert, synchronous deassert.
REQ-008 Ports: cfg_valid in 1; cfg_ready out 1; cfg_funct3 in 3; cfg_funct7 in 7; cfg_rs1 in 32; cfg_rs2 in 32 (operand values).
REQ-009 Ports: rca_busy in NUM_RCAS, RCA executing.
REQ-010 Ports: cfg_pending out NUM_RCAS, queued config targets that RCA.
REQ-011 Ports: cfg_err out 1, one-cycle pulse on a rejected instruction.
REQ-012 Ports: read_addr out NUM_RCAS*NUM_READ_PORTS*5.
REQ-013 Ports: wr_addr_fb and wr_addr_nfb out NUM_RCAS*NUM_WRITE_PORTS*5 each.
REQ-014 Ports: res_sel_fb and res_sel_nfb out NUM_RCAS*NUM_WRITE_PORTS*clog2(NUM_IO_UNITS+1) each.
REQ-015 Ports: grid_sel out NUM_GRID_MUXES*GRID_SEL_W; io_sel out NUM_IO_UNITS*IO_SEL_W; io_use out NUM_RCAS*NUM_READ_PORTS.

Function
REQ-016 Handshake: an instruction SHALL be accepted on a rising edge with cfg_valid=1 and cfg_ready=1; cfg_ready=1 exactly when the queue is not full, independent of cfg_valid.
REQ-017 Funct3 001,010,011,100,101 SHALL be enqueued; 000, 110 and 111 SHALL be rejected: accepted, not enqueued, cfg_err=1 on the following cycle.
REQ-018 Range checks SHALL run at accept and cause rejection, with cfg_err, on failure. Targets: funct7 >= NUM_RCAS for 001/100/101; port index out of range for 001/100; mux index out of range for 010/011.
REQ-019 Queue SHALL be FIFO; at most one head entry applied per edge; apply takes effect on the edge after acceptance at earliest, so outputs are visible 1 cycle after accept.
REQ-020 Head with funct3 001/100/101 SHALL apply only when rca_busy[funct7]=0; funct3 010/011 only when rca_busy is all zero; a blocked head stalls the queue (no reordering).
REQ-021 Apply 001: rs1[2:0] is the port. rs1[3]=0 writes read_addr[funct7][port]=rs2[4:0]. rs1[3]=1 writes wr_addr_fb if rs1[4]=1, else wr_addr_nfb.
REQ-022 Apply 010: grid_sel[rs1]=rs2[GRID_SEL_W-1:0]. Apply 011: io_sel[rs1]=rs2[IO_SEL_W-1:0].
REQ-023 Apply 100: rs1[2:0] is the write port; rs1[3]=1 writes res_sel_fb, else res_sel_nfb; value is rs2 truncated to the sel width.
REQ-024 Apply 101: io_use[funct7]=rs1[NUM_READ_PORTS-1:0].
REQ-025 cfg_pending[i] SHALL be 1 while any queued entry (including head) has funct3 001/100/101 with funct7=i, or funct3 010/011 (all bits); it clears in the cycle after the last such entry applies.
REQ-026 Enqueue and apply on the same edge SHALL both take effect; occupancy is unchanged. When full, no enqueue occurs even if head applies that edge; cfg_ready rises the next cycle.
REQ-027 Pointers SHALL wrap modulo QUEUE_DEPTH; occupancy counter width clog2(QUEUE_DEPTH+1).
REQ-028 Two queued entries to the same field SHALL apply in order; the last one wins.

Reset
REQ-029 On rst_n=0: queue empty, cfg_ready=1, cfg_pending=0, cfg_err=0. All address and res_sel outputs SHALL be set to unused: addresses 0, res_sel = NUM_IO_UNITS. grid_sel, io_sel and io_use SHALL be 0.
REQ-030 Reset mid-operation SHALL discard queued entries; no partial applies.

Verification
REQ-031 Accept 001, funct7=2, rs1=0x03, rs2=7 with RCA2 idle -> read_addr[2][3]=7 one cycle later; cfg_pending[2] pulses for one cycle.
REQ-032 rca_busy[1]=1; send 100 to RCA1 then 101 to RCA0 -> both held and cfg_pending[1:0]=11; busy drops -> applied on consecutive edges in order.
REQ-033 Fill QUEUE_DEPTH=4 entries behind a busy RCA -> cfg_ready=0; 5th valid is not accepted. Release busy -> cfg_ready=1 the cycle after first apply.
REQ-034 funct3=110, and separately 001 with funct7=5 -> cfg_err one-cycle pulse each, no output changes, queue occupancy unchanged.
REQ-035 Send 010 with rs1=29, rs2=5 while any RCA busy -> no change. All idle -> grid_sel[29]=5; rs1=30 -> cfg_err.
REQ-036 Assert rst_n=0 with 3 entries queued -> outputs at reset values and cfg_ready=1; after release, no stale apply occurs.
